// File: rtl/kairo_jtag_pkg.sv
// Shared constants and types for the Kairo JTAG TAP controller.
//   IR_LEN      : instruction register width
//   IR_*        : instruction opcodes and the fixed IR capture pattern
//   tap_state_t : 16-state TAP FSM using the IEEE 1149.1 state encoding
package kairo_jtag_pkg;

  localparam int unsigned IR_LEN = 5;

  localparam logic [IR_LEN-1:0] IR_IDCODE  = 5'h01;
  localparam logic [IR_LEN-1:0] IR_USER    = 5'h10;
  localparam logic [IR_LEN-1:0] IR_BYPASS  = 5'h1F;
  localparam logic [IR_LEN-1:0] IR_CAPTURE = 5'b00001;

  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SH_DR    = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SH_IR    = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_t;

endpackage

// File: rtl/kairo_sync2.sv
// Two-flop synchronizer for a single asynchronous input into the CLK domain.
//   CLK   : destination clock
//   RST_N : synchronous active-low reset; both flops load RST_VAL
//   D     : asynchronous input
//   Q     : synchronized output
import kairo_jtag_pkg::*;

module kairo_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      meta <= RST_VAL;
      Q    <= RST_VAL;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/kairo_jtag_tap.sv
// JTAG TAP controller with IDCODE, USER and BYPASS instructions. TCK is
// oversampled in the CLK domain; all state lives on CLK.
//   CLK, RST_N        : system clock, synchronous active-low reset
//   TRST_N            : asynchronous JTAG test reset (active-low)
//   TCK, TMS, TDI     : JTAG inputs (synchronized internally)
//   TDO, TDO_OE       : JTAG serial output and its drive enable
//   USER_CAPTURE      : parallel value captured into the DR under USER
//   USER_UPDATE       : DR value written at Update-DR under USER
//   USER_UPDATE_VALID : one-CLK strobe accompanying USER_UPDATE writes
//   TAP_STATE         : current TAP state (IEEE 1149.1 encoding)
import kairo_jtag_pkg::*;

module kairo_jtag_tap #(
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        TRST_N,
  input  logic        TCK,
  input  logic        TMS,
  input  logic        TDI,
  output logic        TDO,
  output logic        TDO_OE,
  input  logic [31:0] USER_CAPTURE,
  output logic [31:0] USER_UPDATE,
  output logic        USER_UPDATE_VALID,
  output logic [3:0]  TAP_STATE
);

  logic tck_s, tms_s, tdi_s, trst_n_s;
  logic tck_d;
  logic tck_rise, tck_fall;

  tap_state_t state, state_nxt;

  logic [IR_LEN-1:0] ir, ir_sr;
  logic [31:0]       dr_sr;
  logic              sel_idcode, sel_user;

  kairo_sync2 #(.RST_VAL(1'b0)) u_sync_tck  (.CLK(CLK), .RST_N(RST_N), .D(TCK),    .Q(tck_s));
  kairo_sync2 #(.RST_VAL(1'b1)) u_sync_tms  (.CLK(CLK), .RST_N(RST_N), .D(TMS),    .Q(tms_s));
  kairo_sync2 #(.RST_VAL(1'b0)) u_sync_tdi  (.CLK(CLK), .RST_N(RST_N), .D(TDI),    .Q(tdi_s));
  kairo_sync2 #(.RST_VAL(1'b1)) u_sync_trst (.CLK(CLK), .RST_N(RST_N), .D(TRST_N), .Q(trst_n_s));

  // tck_d resets low alongside the TCK synchronizer, so no edge can be seen
  // until after RST_N releases.
  always_ff @(posedge CLK) begin
    if (!RST_N) tck_d <= 1'b0;
    else        tck_d <= tck_s;
  end

  assign tck_rise = tck_s & ~tck_d;
  assign tck_fall = ~tck_s & tck_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= TAP_TLR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!trst_n_s) begin
      state_nxt = TAP_TLR;
    end else if (tck_rise) begin
      case (state)
        TAP_TLR:      state_nxt = tms_s ? TAP_TLR    : TAP_RTI;
        TAP_RTI:      state_nxt = tms_s ? TAP_SEL_DR : TAP_RTI;
        TAP_SEL_DR:   state_nxt = tms_s ? TAP_SEL_IR : TAP_CAP_DR;
        TAP_CAP_DR:   state_nxt = tms_s ? TAP_EX1_DR : TAP_SH_DR;
        TAP_SH_DR:    state_nxt = tms_s ? TAP_EX1_DR : TAP_SH_DR;
        TAP_EX1_DR:   state_nxt = tms_s ? TAP_UPD_DR : TAP_PAUSE_DR;
        TAP_PAUSE_DR: state_nxt = tms_s ? TAP_EX2_DR : TAP_PAUSE_DR;
        TAP_EX2_DR:   state_nxt = tms_s ? TAP_UPD_DR : TAP_SH_DR;
        TAP_UPD_DR:   state_nxt = tms_s ? TAP_SEL_DR : TAP_RTI;
        TAP_SEL_IR:   state_nxt = tms_s ? TAP_TLR    : TAP_CAP_IR;
        TAP_CAP_IR:   state_nxt = tms_s ? TAP_EX1_IR : TAP_SH_IR;
        TAP_SH_IR:    state_nxt = tms_s ? TAP_EX1_IR : TAP_SH_IR;
        TAP_EX1_IR:   state_nxt = tms_s ? TAP_UPD_IR : TAP_PAUSE_IR;
        TAP_PAUSE_IR: state_nxt = tms_s ? TAP_EX2_IR : TAP_PAUSE_IR;
        TAP_EX2_IR:   state_nxt = tms_s ? TAP_UPD_IR : TAP_SH_IR;
        TAP_UPD_IR:   state_nxt = tms_s ? TAP_SEL_DR : TAP_RTI;
        default:      state_nxt = TAP_TLR;
      endcase
    end
  end

  // Unrecognised opcodes fall through to BYPASS (neither select set).
  always_comb begin
    sel_idcode = 1'b0;
    sel_user   = 1'b0;
    case (ir)
      IR_IDCODE: sel_idcode = 1'b1;
      IR_USER:   sel_user   = 1'b1;
      IR_BYPASS: ;
      default:   ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ir                <= IR_IDCODE;
      ir_sr             <= '0;
      dr_sr             <= '0;
      TDO               <= 1'b0;
      TDO_OE            <= 1'b0;
      USER_UPDATE       <= '0;
      USER_UPDATE_VALID <= 1'b0;
    end else begin
      USER_UPDATE_VALID <= 1'b0;
      if (!trst_n_s) begin
        // Test reset wins over any TCK edge detected in the same cycle.
        ir     <= IR_IDCODE;
        TDO    <= 1'b0;
        TDO_OE <= 1'b0;
      end else begin
        if (tck_rise) begin
          case (state)
            TAP_CAP_IR: ir_sr <= IR_CAPTURE;
            TAP_SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
            TAP_UPD_IR: ir    <= ir_sr;
            TAP_CAP_DR: begin
              if (sel_idcode)    dr_sr <= IDCODE;
              else if (sel_user) dr_sr <= USER_CAPTURE;
              else               dr_sr <= '0;
            end
            TAP_SH_DR: begin
              // BYPASS is a 1-bit register living in dr_sr[0].
              if (sel_idcode || sel_user) dr_sr    <= {tdi_s, dr_sr[31:1]};
              else                        dr_sr[0] <= tdi_s;
            end
            TAP_UPD_DR: begin
              if (sel_user) begin
                USER_UPDATE       <= dr_sr;
                USER_UPDATE_VALID <= 1'b1;
              end
            end
            default: ;
          endcase
          if (state_nxt == TAP_TLR) ir <= IR_IDCODE;
        end
        if (tck_fall) begin
          case (state)
            TAP_SH_IR: begin
              TDO    <= ir_sr[0];
              TDO_OE <= 1'b1;
            end
            TAP_SH_DR: begin
              TDO    <= dr_sr[0];
              TDO_OE <= 1'b1;
            end
            default: begin
              TDO    <= 1'b0;
              TDO_OE <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign TAP_STATE = state;

endmodule

// File: doc/kairo_jtag_tap.md
KAIRO_JTAG_TAP -- requirements
Module: kairo_jtag_tap

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1000_0001, meaning device ID returned by the IDCODE instruction; bit 0 SHALL be 1.
REQ-002 SHALL have port CLK  input  1  system clock; all state in this domain.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port TRST_N  input  1  JTAG test reset, asynchronous to CLK, active-low.
REQ-005 SHALL have port TCK  input  1  JTAG clock, oversampled by CLK.
REQ-006 SHALL have port TMS  input  1  JTAG mode select.
REQ-007 SHALL have port TDI  input  1  JTAG serial data in.
REQ-008 SHALL have port TDO  output  1  JTAG serial data out.
REQ-009 SHALL have port TDO_OE  output  1  TDO drive enable.
REQ-010 SHALL have port USER_CAPTURE  input  32  parallel value loaded at Capture-DR under USER.
REQ-011 SHALL have port USER_UPDATE  output  32  value latched at Update-DR under USER.
REQ-012 SHALL have port USER_UPDATE_VALID  output  1  one-CLK pulse when USER_UPDATE is written.
REQ-013 SHALL have port TAP_STATE  output  4  current TAP state, IEEE 1149.1 encoding.

Function
REQ-014 SHALL pass TCK, TMS, TDI and TRST_N each through a 2-flop synchronizer on CLK.
REQ-015 SHALL detect TCK rise/fall as a change of synchronized TCK versus its previous CLK sample; TMS/TDI SHALL be the synchronized values in the rise-detect cycle.
REQ-016 SHALL update TAP state and shift registers within 3 CLK of a TCK input rise; TCK high and low phases SHALL each be at least 4 CLK periods.
REQ-017 SHALL implement the 16-state TAP FSM with encodings TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D, with standard TMS transitions.
REQ-018 SHALL hold a 5-bit IR; opcodes IDCODE=5'h01, USER=5'h10, BYPASS=5'h1F; any other opcode SHALL select BYPASS.
REQ-019 SHALL, on a TCK rise while in CapIR, load the IR shift register with 5'b00001.
REQ-020 SHALL, on a TCK rise while in ShIR or ShDR, shift the selected register right with TDI entering the MSB.
REQ-021 SHALL, on a TCK rise while in UpdIR, copy the IR shift register to the IR.
REQ-022 SHALL, on a TCK rise while in CapDR, load the DR shift register with IDCODE, USER_CAPTURE, or 1'b0 (BYPASS, 1-bit) according to IR.
REQ-023 SHALL, on a TCK rise while in UpdDR with IR=USER, write the 32-bit DR shift register to USER_UPDATE and assert USER_UPDATE_VALID for exactly one CLK.
REQ-024 SHALL, on a TCK fall while in ShIR/ShDR, set TDO to the LSB of the selected shift register and TDO_OE to 1; on a TCK fall in any other state, TDO=0 and TDO_OE=0.
REQ-025 SHALL, on entering TLR by any path, set IR to IDCODE.
REQ-026 SHALL give synchronized TRST_N low priority over a same-cycle TCK edge: state goes to TLR, IR goes to IDCODE, TDO_OE goes to 0, and no USER_UPDATE_VALID pulse is issued.

Reset
REQ-027 SHALL, while RST_N is low at a CLK edge, set TAP_STATE=F, IR=5'h01, shift registers=0, TDO=0, TDO_OE=0, USER_UPDATE=0, USER_UPDATE_VALID=0, and synchronizers to TCK=0, TMS=1, TDI=0, TRST_N=1.
REQ-028 SHALL ignore TCK edges occurring during RST_N low; the first edge counted SHALL be the first edge detected after release.

Structure
REQ-029 SHALL place the TAP state enum, IR opcodes and IR length constant in package kairo_jtag_pkg.
REQ-030 SHALL use one sub-module kairo_sync2 (2-flop synchronizer with reset value parameter), instantiated four times.

Verification
REQ-031 Bench SHALL drive RST_N low for 5 CLK -> TAP_STATE=F, TDO_OE=0, USER_UPDATE=0.
REQ-032 Bench SHALL, from ShDR, apply 5 TCK with TMS=1 -> TAP_STATE=F and IR=5'h01.
REQ-033 Bench SHALL, after reset, apply TMS 0,1,0,0 and then 32 ShDR clocks -> TDO emits 32'h1000_0001 LSB first.
REQ-034 Bench SHALL shift IR=5'h10 -> TDO emits 00001 during ShIR; then with USER_CAPTURE=32'hA5A5_5A5A a DR scan shifting in 32'hDEAD_BEEF -> TDO emits A5A5_5A5A and USER_UPDATE=32'hDEAD_BEEF with a single 1-CLK USER_UPDATE_VALID pulse.
REQ-035 Bench SHALL set IR=5'h1F and shift TDI pattern 1,0,1,1 -> TDO emits 0,1,0,1,1 (one TCK delay).
REQ-036 Bench SHALL pulse TRST_N low mid-ShDR under USER -> TAP_STATE=F within 3 CLK, IR=5'h01, no USER_UPDATE_VALID pulse.
